// File: rtl/bcd_seg_scanner_if.sv
// Load/result bus from the BCD adder plus the multiplexed display outputs.
interface bcd_seg_scanner_if;
  logic       load;
  logic [7:0] result;
  logic       out_of_range;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       dp_n;
  logic       err;

  modport master (
    output load, result, out_of_range,
    input  seg_n, an_n, dp_n, err
  );

  modport slave (
    input  load, result, out_of_range,
    output seg_n, an_n, dp_n, err
  );
endinterface

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: captures legal BCD adder sums, counts them (2-digit BCD,
// wraps 99->00) and scans a 4-digit active-low seven-segment display:
// count on digits 3..2, sum on digits 1..0, E/r on digits 1..0 while err.
// Optional build macro BCD_LZB_EN enables leading-zero blanking of the
// tens digits (digit 1 only when not showing an error).
module bcd_seg_scanner #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input logic             clk,
  input logic             reset_n,
  bcd_seg_scanner_if.slave bus
);

  localparam int DIV_W = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Glyph codes beyond the decimal digits.
  localparam logic [3:0] G_BLANK = 4'd10;
  localparam logic [3:0] G_E     = 4'd11;
  localparam logic [3:0] G_R     = 4'd12;

  logic             sum_tens;
  logic [3:0]       sum_ones;
  logic [3:0]       cnt_tens;
  logic [3:0]       cnt_ones;
  logic             err_q;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [3:0]       glyph;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;
  logic             dp_q;
  logic             load_ok;

  function automatic logic [6:0] seg_of(input logic [3:0] g);
    case (g)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      G_E:     return 7'b0000110;
      G_R:     return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

  // The [4:0] bound is a raw binary compare against 19, so 0x14..0x19 are
  // rejected even though their ones digit is a valid BCD digit.
  assign load_ok = !bus.out_of_range
                && (bus.result[7:5] == 3'b000)
                && (bus.result[3:0] <= 4'd9)
                && (bus.result[4:0] <= 5'd19);

  // Capture legal sums, bump the BCD count, latch/clear the error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_tens <= 1'b0;
      sum_ones <= 4'd0;
      cnt_tens <= 4'd0;
      cnt_ones <= 4'd0;
      err_q    <= 1'b0;
    end else if (bus.load) begin
      if (load_ok) begin
        sum_tens <= bus.result[4];
        sum_ones <= bus.result[3:0];
        err_q    <= 1'b0;
        if (cnt_ones == 4'd9) begin
          cnt_ones <= 4'd0;
          cnt_tens <= (cnt_tens == 4'd9) ? 4'd0 : cnt_tens + 4'd1;
        end else begin
          cnt_ones <= cnt_ones + 4'd1;
        end
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  // Scan divider: hold each digit SCAN_DIV cycles, then advance idx mod 4.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Pick the glyph for the currently selected digit.
  always_comb begin
    glyph = 4'd0;
    case (idx)
      2'd0: glyph = err_q ? G_R : sum_ones;
      2'd1: begin
        if (err_q)
          glyph = G_E;
`ifdef BCD_LZB_EN
        else if (!sum_tens)
          glyph = G_BLANK;
`endif
        else
          glyph = {3'b000, sum_tens};
      end
      2'd2: glyph = cnt_ones;
      default: begin
`ifdef BCD_LZB_EN
        glyph = (cnt_tens == 4'd0) ? G_BLANK : cnt_tens;
`else
        glyph = cnt_tens;
`endif
      end
    endcase
  end

  // Registered display drive: one cycle behind idx and digit state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(4'b0001 << idx);
      seg_q <= seg_of(glyph);
      dp_q  <= (idx != 2'd2);
    end
  end

  assign bus.an_n  = an_q;
  assign bus.seg_n = seg_q;
  assign bus.dp_n  = dp_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner: vector table, hand corner sequences and random
// loads, all checked every cycle against a value-level display model.
module tb_bcd_seg_scanner;
  localparam int SD = 4;

`ifdef BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bcd_seg_scanner_if bus();

  bcd_seg_scanner #(.SCAN_DIV(SD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: sum and count as plain integers, err bit, edges since release.
  int m_sum, m_cnt, m_k;
  bit m_err;

  // 0..9 digits, 10 blank, 11 E, 12 r
  logic [6:0] seg_tab [13];

  typedef struct {
    logic [7:0] r;
    bit         o;
    bit         exp_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [7:0] r, input bit o);
    int v;
    v = int'(r);
    return !o && v <= 19 && (v % 16) <= 9;
  endfunction

  function automatic int glyph(input int idx);
    case (idx)
      0: return m_err ? 12 : m_sum % 10;
      1: return m_err ? 11 : ((LZB && m_sum < 10) ? 10 : m_sum / 10);
      2: return m_cnt % 10;
      default: return (LZB && m_cnt < 10) ? 10 : m_cnt / 10;
    endcase
  endfunction

  function automatic void model_reset();
    m_sum = 0; m_cnt = 0; m_err = 0; m_k = 0;
  endfunction

  // One clock: drive inputs, predict outputs from pre-edge model state,
  // update the model, compare at the falling edge.
  task automatic cyc(input bit ld, input logic [7:0] r, input bit o);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    bit         e_dp;
    int         idx;
    bus.load = ld; bus.result = r; bus.out_of_range = o;
    @(posedge clk);
    idx   = (m_k / SD) % 4;
    m_k++;
    e_an  = ~(4'b0001 << idx);
    e_seg = seg_tab[glyph(idx)];
    e_dp  = (idx != 2);
    if (ld) begin
      if (legal(r, o)) begin
        m_sum = int'(r) / 16 * 10 + int'(r) % 16;
        m_cnt = (m_cnt + 1) % 100;
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end
    @(negedge clk);
    chk("an_n", bus.an_n, e_an);
    chk("seg_n", bus.seg_n, e_seg);
    chk("dp_n", bus.dp_n, e_dp);
    chk("err", bus.err, m_err);
  endtask

  // Idle until digit idx is driven (bounded), then check it against a constant.
  task automatic show(input int idx, input logic [6:0] exp, input string name);
    logic [3:0] want_an;
    int n;
    want_an = ~(4'b0001 << idx);
    n = 0;
    do begin
      cyc(1'b0, 8'h00, 1'b0);
      n++;
    end while (bus.an_n !== want_an && n < 8 * SD);
    chk(name, {bus.an_n, bus.seg_n}, {want_an, exp});
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {bus.an_n, bus.seg_n, bus.dp_n, bus.err}, {4'b1111, 7'h7F, 1'b1, 1'b0});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected end before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [12];
    logic [3:0] an_seq [4];
    logic [6:0] blank_or_zero;
    int n;

    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b1111111; seg_tab[11] = 7'b0000110;
    seg_tab[12] = 7'b0101111;
    blank_or_zero = LZB ? 7'b1111111 : 7'b1000000;

    an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;

    vecs[0]  = '{8'h13, 1'b0, 1'b0};
    vecs[1]  = '{8'h0C, 1'b0, 1'b1};
    vecs[2]  = '{8'h05, 1'b0, 1'b0};
    vecs[3]  = '{8'h02, 1'b1, 1'b1};
    vecs[4]  = '{8'h22, 1'b0, 1'b1};
    vecs[5]  = '{8'h19, 1'b0, 1'b1};
    vecs[6]  = '{8'h14, 1'b0, 1'b1};
    vecs[7]  = '{8'h0A, 1'b0, 1'b1};
    vecs[8]  = '{8'h00, 1'b0, 1'b0};
    vecs[9]  = '{8'h09, 1'b0, 1'b0};
    vecs[10] = '{8'h10, 1'b0, 1'b0};
    vecs[11] = '{8'h80, 1'b0, 1'b1};

    bus.load = 1'b0; bus.result = 8'h00; bus.out_of_range = 1'b0;
    model_reset();
    #12;
    chk_reset_outputs("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    // Scan order and hold time straight out of reset.
    for (int i = 0; i < 4 * SD; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      chk("scan_an", bus.an_n, an_seq[i / SD]);
      chk("scan_dp", bus.dp_n, (i / SD) != 2);
    end

    // Legal 13, then illegal 0C shows E/r, then 05 clears it.
    cyc(1'b1, 8'h13, 1'b0);
    show(0, 7'b0110000, "ld13_d0");
    show(1, 7'b1111001, "ld13_d1");
    show(2, 7'b1111001, "ld13_d2");
    show(3, blank_or_zero, "ld13_d3");
    cyc(1'b1, 8'h0C, 1'b0);
    show(1, 7'b0000110, "err_E");
    show(0, 7'b0101111, "err_r");
    show(2, 7'b1111001, "err_cnt_kept");
    cyc(1'b1, 8'h05, 1'b0);
    show(0, 7'b0010010, "ld05_d0");
    show(1, blank_or_zero, "ld05_d1");
    show(2, 7'b0100100, "ld05_cnt2");

    // Vector table, applied back to back (load held high).
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, vecs[i].r, vecs[i].o);
      chk("vec_err", bus.err, vecs[i].exp_err);
    end
    cyc(1'b0, 8'h00, 1'b0);

    // Async reset mid-scan, no clock edge needed.
    cyc(1'b0, 8'h00, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    chk_reset_outputs("reset_held");
    model_reset();
    reset_n = 1'b1;

    // Count wrap 99 -> 00.
    for (int i = 0; i < 99; i++)
      cyc(1'b1, 8'($urandom_range(0, 9)), 1'b0);
    show(2, 7'b0010000, "cnt99_d2");
    show(3, 7'b0010000, "cnt99_d3");
    cyc(1'b1, 8'h01, 1'b0);
    show(2, 7'b1000000, "cnt00_d2");
    show(3, blank_or_zero, "cnt00_d3");

    // Load on the same edge the scan wraps from digit 3 to digit 0.
    n = 0;
    while (!((m_k % SD) == SD - 1 && ((m_k / SD) % 4) == 3) && n < 8 * SD) begin
      cyc(1'b0, 8'h00, 1'b0);
      n++;
    end
    cyc(1'b1, 8'h07, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("simul_load_wrap", {bus.an_n, bus.seg_n}, {4'b1110, 7'b1111000});

    // Random loads against the model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = ($urandom % 4 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
      cyc(($urandom % 2) == 1, r, ($urandom % 8) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_seg_scanner.md
Name: bcd_seg_scanner

Overview:
- Downstream consumer of the 4-bit BCD adder's 8-bit result and out_of_range flag.
- Captures each valid sum on a load strobe and keeps a 2-digit BCD count of accepted sums.
- Drives a 4-digit multiplexed, active-low seven-segment display: count on digits 3..2, sum on digits 1..0.
- Flags illegal adder output or input as an error, shown on the display.

Parameters:
- SCAN_DIV, default 1000: clk cycles each digit is held before the scan advances; legal range 2..65535.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- load, input, 1: one-cycle strobe; sample result and out_of_range on this edge.
- result, input, 8: adder sum. [4] is the tens digit (0/1), [3:0] is the ones digit, [7:5] are expected 0.
- out_of_range, input, 1: illegal-input flag from the adder.
- seg_n, output, 7: active-low segments. [0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g.
- an_n, output, 4: active-low digit enables, one-hot-low. [0] is the rightmost digit.
- dp_n, output, 1: active-low decimal point.
- err, output, 1: error flag, level.

Behaviour:
- Reset (async, reset_n=0):
  - sum_tens=0, sum_ones=0, cnt_tens=0, cnt_ones=0, err=0.
  - div counter=0, digit index idx=0.
  - an_n=4'b1111, seg_n=7'h7F, dp_n=1.
- Reset release: outputs go live at the first rising edge after deassertion.
- Load validation at a rising edge with load=1. The load is illegal if any of:
  - out_of_range=1
  - result[7:5]!=0
  - result[3:0]>9
  - result[4:0]>19
- Illegal load: err<=1; sum and count unchanged.
- Legal load:
  - sum_tens<=result[4], sum_ones<=result[3:0], err<=0.
  - Count increments in BCD: ones 9 wraps to 0 with carry into tens; count 99 wraps to 00.
- load=0: nothing changes. Back-to-back loads (load held high) are each evaluated, one per cycle.
- Scan timing:
  - div counts 0..SCAN_DIV-1.
  - When div==SCAN_DIV-1: div<=0 and idx<=idx+1 mod 4, giving order 0,1,2,3,0,...
  - Each digit is held exactly SCAN_DIV cycles.
- Output register: an_n, seg_n and dp_n are registered from idx and the digit state of the previous cycle, so there is 1-cycle latency.
  - A load that updates digits is visible on seg_n one cycle later, when its digit is selected.
  - A load and a scan advance in the same cycle both take effect; there is no priority conflict.
- an_n: bit idx low, all other bits high.
- dp_n: 0 when idx==2 (separates count from sum), else 1.
- Segment codes (seg_n, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, E=0000110, r=0101111
- Digit mapping:
  - idx0 = sum_ones, idx1 = sum_tens, idx2 = cnt_ones, idx3 = cnt_tens.
- Error display: while err=1, idx1 shows E and idx0 shows r. idx3..2 keep showing the count.
- err clears only on the next legal load or on reset.

Optional Feature:
- Macro: BCD_LZB_EN.
- Defined: leading-zero blanking.
  - idx1 shows blank when sum_tens==0 and err=0.
  - idx3 shows blank when cnt_tens==0.
  - Units digits are never blanked.
- Undefined: all zeros are displayed. The E/r error display is unaffected by this macro.

Test Plan:
- Reset: hold reset_n=0 mid-scan -> an_n=1111, seg_n=7F, dp_n=1, err=0 immediately, with no clock required. After release with SCAN_DIV=4 -> an_n sequence 1110, 1101, 1011, 0111, each held 4 cycles, dp_n=0 only during 1011.
- Legal load: load with result=8'h13 -> next frame shows idx0 seg_n=0110000 ('3'), idx1 1111001 ('1'), idx2 '1', idx3 '0' (blank if BCD_LZB_EN), err=0.
- Illegal loads:
  - result=8'h0C -> err=1, idx1/idx0 show E/r, count unchanged.
  - Then result=8'h05 -> err=0, count increments, idx0 shows '5', idx1 shows '0' (blank if BCD_LZB_EN).
- out_of_range: load with out_of_range=1 and result=8'h02 -> err=1, count unchanged. Repeat with result=8'h22 (bit 5 set) -> err=1.
- Count wrap: 99 legal loads -> cnt=99. The 100th load -> cnt=00, digits show '0' (blank on idx3 if BCD_LZB_EN).
- Simultaneous: load of 8'h07 on the cycle div==SCAN_DIV-1 while idx==3 -> idx becomes 0, and seg_n shows '7' on the following cycle with an_n=1110.
